// File: rtl/key_event_ctrl.sv
// Debounced multi-key front end: per-key press detection, round-robin arbitration
// and a read-to-acknowledge event word on the CPU bus.
module key_event_ctrl #(
    parameter int unsigned NKEYS   = 4,
    parameter int unsigned CLKRATE = 25000000,
    parameter int unsigned DBMSEC  = 150,
    parameter int unsigned ADDR    = 411700
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    input  logic [31:0]      busaddr,
    output logic [31:0]      busdata
);

    localparam int unsigned DBMAX = (CLKRATE / 1000) * DBMSEC;
    localparam int unsigned CW    = (DBMAX < 2) ? 1 : $clog2(DBMAX + 1);
    localparam int unsigned KW    = (NKEYS < 2) ? 1 : $clog2(NKEYS);

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } key_state_e;

    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] ks_q;
    key_state_e       state_q [NKEYS];
    key_state_e       state_d [NKEYS];
    logic [CW-1:0]    cnt_q   [NKEYS];
    logic [CW-1:0]    cnt_d   [NKEYS];
    logic [NKEYS-1:0] press;

    logic [NKEYS-1:0] pending_q, pending_d;
    logic [NKEYS-1:0] gmask;
    logic [NKEYS-1:0] drop_hit;
    logic [KW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [KW-1:0]    grant_idx;
    logic             grant_found;
    logic             ev_valid_q, ev_valid_d;
    logic [3:0]       ev_key_q, ev_key_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             match_q;
    logic             match;
    logic             ack;
    logic             load;
    int               best_off;
    int               off;
    int               drop_sum;

    // Synchronizers, debounce state and event slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '1;
            ks_q       <= '1;
            for (int k = 0; k < int'(NKEYS); k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            drop_cnt_q <= '0;
            match_q    <= 1'b0;
        end else begin
            sync1_q    <= key;
            ks_q       <= sync1_q;
            for (int k = 0; k < int'(NKEYS); k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            drop_cnt_q <= drop_cnt_d;
            match_q    <= match;
        end
    end

    // Per-key debounce: a press fires on release after DBMAX cycles held low
    always_comb begin
        press = '0;
        for (int k = 0; k < int'(NKEYS); k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    if (!ks_q[k]) begin
                        state_d[k] = ST_COUNT;
                        cnt_d[k]   = CW'(1);
                    end
                end
                ST_COUNT: begin
                    if (!ks_q[k]) begin
                        if (cnt_q[k] < CW'(DBMAX)) begin
                            cnt_d[k] = cnt_q[k] + CW'(1);
                        end
                    end else begin
                        press[k]   = (cnt_q[k] >= CW'(DBMAX));
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // Round-robin grant: pending key closest at or after rr_ptr wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        best_off    = int'(NKEYS);
        off         = 0;
        for (int k = 0; k < int'(NKEYS); k++) begin
            off = (k + int'(NKEYS) - int'(rr_ptr_q)) % int'(NKEYS);
            if (pending_q[k] && (off < best_off)) begin
                best_off    = off;
                grant_idx   = KW'(k);
                grant_found = 1'b1;
            end
        end
    end

    assign match = (busaddr == 32'(ADDR));
    assign ack   = match & ~match_q & ev_valid_q;
    assign load  = (~ev_valid_q | ack) & grant_found;

    // Pending set/clear, drop counting and output slot update
    always_comb begin
        gmask      = load ? (NKEYS'(1) << grant_idx) : '0;
        drop_hit   = press & pending_q & ~gmask;
        pending_d  = (pending_q & ~gmask) | press;
        rr_ptr_d   = rr_ptr_q;
        ev_valid_d = ev_valid_q;
        ev_key_d   = ev_key_q;
        drop_sum   = ack ? 0 : int'(drop_cnt_q);
        for (int k = 0; k < int'(NKEYS); k++) begin
            if (drop_hit[k]) begin
                drop_sum = drop_sum + 1;
            end
        end
        drop_cnt_d = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
        if (load) begin
            ev_valid_d = 1'b1;
            ev_key_d   = 4'(grant_idx);
            rr_ptr_d   = KW'((int'(grant_idx) + 1) % int'(NKEYS));
        end else if (ack) begin
            ev_valid_d = 1'b0;
        end
    end

    assign busdata = {ev_valid_q, 15'd0, drop_cnt_q, 4'd0, ev_key_q};

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Multi-key front end for the SoC bus. Debounces NKEYS active-low push keys and queues one completed press per key.
- Arbitrates pending presses round-robin and presents one event at a time on a read-to-acknowledge bus word at address ADDR.
- Replaces per-key single-bit button interfaces where the CPU polls several keys through one address.

Parameters:
- NKEYS, 4, number of keys (1..16).
- CLKRATE, 25000000, clk frequency in Hz.
- DBMSEC, 150, debounce hold time in ms.
- ADDR, 411700, bus address of the event word.
- DBMAX (localparam), (CLKRATE/1000)*DBMSEC, cycles of stable low required for a valid press.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- key  input  NKEYS  raw keys, active-low, asynchronous to clk.
- busaddr  input  32  CPU bus address.
- busdata  output  32  event word, combinational from registers only.

Behaviour:
- Reset (async, rst=1): synchronizers=1 (released); all debounce counters=0; all per-key FSMs=IDLE; pending=0; rr_ptr=0; ev_valid=0; ev_key=0; drop_cnt=0; match_q=0; busdata=0.
- Sync: each key passes through a 2-flop synchronizer (ks). Every timing below counts from the synchronized value.
- Per-key FSM, independent per key:
  - IDLE: ks=0 -> COUNT with cnt=1.
  - COUNT: ks=0 -> cnt++ (saturates at DBMAX); ks=1 and cnt>=DBMAX -> emit press, go IDLE, cnt=0; ks=1 and cnt<DBMAX -> IDLE, cnt=0 (glitch rejected).
  - A press is emitted on release after at least DBMAX cycles low. There is no event while the key is held.
- Pending: press on key k sets pending[k] at the same edge.
  - If pending[k] is already 1 and is not being granted at that edge: drop_cnt++ (saturates at 255); pending stays 1.
  - Set wins over grant-clear on the same edge.
- Acknowledge: match = (busaddr==ADDR); match_q registers match.
  - ack = match & ~match_q & ev_valid. Only the first cycle of an address match acknowledges, so a multi-cycle access acknowledges once.
  - Reads while ev_valid=0 have no effect.
- Output slot load: when (ev_valid=0 or ack) and pending!=0:
  - Grant the first set pending bit searching from rr_ptr upward, wrapping at NKEYS.
  - ev_key=granted; ev_valid=1; pending[granted]=0; rr_ptr=(granted+1) mod NKEYS.
  - If ack and pending=0: ev_valid=0, ev_key holds.
- Latency: pending set at edge t -> ev_valid=1 after edge t+1 if the slot is empty. Key release to busdata valid = 2 sync + 1 detect + 1 load edges.
- Same-cycle ack and load: the next event replaces the current one at that edge. There is no bubble cycle.
- busdata format:
  - [31]=ev_valid
  - [15:8]=drop_cnt
  - [3:0]=ev_key
  - all other bits 0
- drop_cnt clears to 0 on every ack.
- A key held forever keeps its FSM in COUNT with cnt=DBMAX and never emits.
- rst mid-debounce or mid-event: everything returns to reset values immediately; in-flight and pending events are discarded.

Test Plan:
All scenarios use CLKRATE=1000, DBMSEC=4 (DBMAX=4), NKEYS=4.
- Reset: key=4'hF, rst pulse mid-cycle -> busdata=0 asynchronously; hold key0 low 10 cycles then assert rst -> no event after release.
- Debounce: key0 low 3 cycles then high -> busdata[31] stays 0. Key0 low 6 cycles then high -> busdata=32'h8000_0000 exactly 4 edges after release.
- Ack: busaddr=ADDR held 5 cycles with one event valid -> busdata[31] falls after the first edge only; a second event queued behind it is presented and not consumed.
- Round-robin: keys 0,1,2,3 all released the same cycle -> successive acks read ev_key 0,1,2,3. Then keys 3 and 1 released together with rr_ptr=0 -> order 1, 3.
- Drop: key2 pressed and released twice with no ack while the slot holds key0 -> pending[2] set once, busdata[15:8]=1. After ack: busdata shows key2 with drop_cnt=0.
- Contention: key1 press emitted on the same edge as ack granting pending key1 -> key1 re-presented on the following ack and drop_cnt unchanged.
